// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wisc_pkg
//  Description : Shared opcode encoding, flag/entry types, buffer count
//                encoding and the per-opcode flag update mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package wisc_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 4;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LHB    = 4'b1010,
    OP_LLB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_e;

  // Packed MSB-first so that a flags_t reads as {Z,V,N}
  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  typedef struct packed {
    logic [DW_DEF-1:0] result;
    logic [RW_DEF-1:0] dst;
    logic              wr_en;
    opcode_e           opcode;
  } ex_entry_t;

  // Occupancy encoding of the 2-entry result buffer
  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  // Which of Z/V/N an opcode is allowed to update when it enters the buffer
  function automatic flags_t flag_mask(input opcode_e op);
    flags_t m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m.z = 1'b1;
      default:                        m = '0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : ex_skid_buf
//  Description : 2-entry in-order FIFO with count FSM. Slot 0 is always the
//                head; slot 1 holds the younger entry when full. push/pop are
//                expected pre-qualified (no push while full, no pop while
//                empty). flush empties the buffer and overrides push/pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_skid_buf
  import wisc_pkg::*;
#(
  parameter type entry_t = wisc_pkg::ex_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  logic   pop_i,
  input  logic   flush_i,
  input  entry_t wdata_i,
  output entry_t rdata_o,
  output logic   empty_o,
  output logic   full_o
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  entry_t     slot0_q;
  entry_t     slot1_q;

  // Count state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_EMPTY;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count next-state: flush wins over any push/pop in the same cycle
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = CNT_EMPTY;
    end else begin
      case (cnt_q)
        CNT_EMPTY: if (push_i) cnt_d = CNT_ONE;
        CNT_ONE: begin
          if (push_i && !pop_i) begin
            cnt_d = CNT_FULL;
          end else if (pop_i && !push_i) begin
            cnt_d = CNT_EMPTY;
          end
        end
        CNT_FULL:  if (pop_i) cnt_d = CNT_ONE;
        default:   cnt_d = CNT_EMPTY;
      endcase
    end
  end

  // Status outputs decoded from the registered count only
  always_comb begin
    empty_o = (cnt_q == CNT_EMPTY);
    full_o  = (cnt_q == CNT_FULL);
  end

  // Entry storage: keep the head in slot 0, shifting slot 1 up on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= entry_t'('0);
      slot1_q <= entry_t'('0);
    end else if (!flush_i) begin
      case (cnt_q)
        CNT_EMPTY: begin
          if (push_i) slot0_q <= wdata_i;
        end
        CNT_ONE: begin
          if (push_i && pop_i) begin
            slot0_q <= wdata_i;
          end else if (push_i) begin
            slot1_q <= wdata_i;
          end
        end
        CNT_FULL: begin
          if (pop_i) slot0_q <= slot1_q;
        end
        default: ;
      endcase
    end
  end

  assign rdata_o = slot0_q;

endmodule
`default_nettype wire

// File: rtl/ex_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_flag_stage
//  Description : Execute-stage output block. Buffers ALU results for the
//                memory stage, maintains the Z/V/N flag register and tracks
//                HLT so the pipeline drains before halting.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_flag_stage
  import wisc_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_opcode,
  input  logic [DW-1:0] in_sum,
  input  logic          in_ovfl,
  input  logic [RW-1:0] in_dst,
  input  logic          in_wr_en,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_dst,
  output logic          out_wr_en,
  output logic [3:0]    out_opcode,
  output logic [2:0]    flags,
  output logic          halted
);

  typedef struct packed {
    logic [DW-1:0] result;
    logic [RW-1:0] dst;
    logic          wr_en;
    opcode_e       opcode;
  } entry_t;

  opcode_e in_op;
  entry_t  wr_entry;
  entry_t  head;
  logic    buf_empty;
  logic    buf_full;
  logic    push;
  logic    pop;
  flags_t  flags_q;
  flags_t  flags_d;
  flags_t  upd_mask;
  logic    hlt_pending_q;
  logic    hlt_pending_d;
  logic    halted_q;
  logic    halted_d;

  assign in_op = opcode_e'(in_opcode);

  // in_ready depends on registered state only, never on same-cycle inputs
  assign in_ready  = ~buf_full & ~hlt_pending_q & ~halted_q;
  assign out_valid = ~buf_empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign wr_entry.result = in_sum;
  assign wr_entry.dst    = in_dst;
  assign wr_entry.wr_en  = in_wr_en;
  assign wr_entry.opcode = in_op;

  ex_skid_buf #(
    .entry_t (entry_t)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );

  // Head data; write enable is masked so an empty buffer never requests a write
  assign out_result = head.result;
  assign out_dst    = head.dst;
  assign out_opcode = head.opcode;
  assign out_wr_en  = out_valid & head.wr_en;

  assign flags  = flags_q;
  assign halted = halted_q;

  // Flag next-state: only accepted instructions update, gated per opcode
  always_comb begin
    flags_d  = flags_q;
    upd_mask = flag_mask(in_op);
    if (push) begin
      if (upd_mask.z) flags_d.z = (in_sum == '0);
      if (upd_mask.v) flags_d.v = in_ovfl;
      if (upd_mask.n) flags_d.n = in_sum[DW-1];
    end
  end

  // HLT tracking: pending from HLT push to HLT pop, then halted sticks
  always_comb begin
    hlt_pending_d = hlt_pending_q;
    halted_d      = halted_q;
    if (flush) begin
      hlt_pending_d = 1'b0;
    end else begin
      if (pop && (head.opcode == OP_HLT)) begin
        hlt_pending_d = 1'b0;
        halted_d      = 1'b1;
      end
      if (push && (in_op == OP_HLT)) begin
        hlt_pending_d = 1'b1;
      end
    end
  end

  // Flag and HLT state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q       <= '0;
      hlt_pending_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      hlt_pending_q <= hlt_pending_d;
      halted_q      <= halted_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_flag_stage
//  Description : Self-checking bench for ex_flag_stage: directed vector table,
//                hand-written multi-cycle sequences and a randomized run
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_sum;
  logic        in_ovfl;
  logic [3:0]  in_dst;
  logic        in_wr_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        out_wr_en;
  logic [3:0]  out_opcode;
  logic [2:0]  flags;
  logic        halted;

  always #5 clk = ~clk;

  ex_flag_stage #(.DW(16), .RW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_sum     (in_sum),
    .in_ovfl    (in_ovfl),
    .in_dst     (in_dst),
    .in_wr_en   (in_wr_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dst    (out_dst),
    .out_wr_en  (out_wr_en),
    .out_opcode (out_opcode),
    .flags      (flags),
    .halted     (halted)
  );

  // Reference model state
  typedef struct {
    logic [15:0] result;
    logic [3:0]  dst;
    logic        wr_en;
    logic [3:0]  op;
  } mentry_t;

  mentry_t    mq[$];
  logic [2:0] mflags;
  bit         mpend;
  bit         mhalted;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [15:0] sum;
    logic        ovfl;
    logic [3:0]  dst;
    logic [2:0]  e_flags;
    logic        e_valid;
    logic [15:0] e_result;
    logic        e_ready;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [15:0] sum,
                        input logic ovfl, input logic [3:0] dst, input logic wr,
                        input logic ordy, input logic fl);
    in_valid  = v;
    in_opcode = op;
    in_sum    = sum;
    in_ovfl   = ovfl;
    in_dst    = dst;
    in_wr_en  = wr;
    out_ready = ordy;
    flush     = fl;
  endtask

  function automatic bit model_ready();
    return (mq.size() < 2) && !mpend && !mhalted;
  endfunction

  // One clock cycle: model consumes the current inputs, returns at the next negedge
  task automatic tick();
    bit      rdy;
    mentry_t e;
    rdy = model_ready();
    if (flush) begin
      mq.delete();
      mpend = 1'b0;
    end else begin
      if (mq.size() > 0 && out_ready) begin
        e = mq.pop_front();
        if (e.op == 4'hF) begin
          mpend   = 1'b0;
          mhalted = 1'b1;
        end
      end
      if (in_valid && rdy) begin
        e.result = in_sum;
        e.dst    = in_dst;
        e.wr_en  = in_wr_en;
        e.op     = in_opcode;
        mq.push_back(e);
        case (in_opcode)
          4'h0, 4'h1:             mflags = {in_sum == 16'h0, in_ovfl, in_sum[15]};
          4'h2, 4'h4, 4'h5, 4'h6: mflags[2] = (in_sum == 16'h0);
          default: ;
        endcase
        if (in_opcode == 4'hF) mpend = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    mq.delete();
    mflags  = 3'b000;
    mpend   = 1'b0;
    mhalted = 1'b0;
  endtask

  task automatic do_reset();
    set_in(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Assert reset between edges and check that outputs clear without a clock
  task automatic async_rst_check(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_valid"},  out_valid, 1'b0);
    chk({tag, "_wr_en"},  out_wr_en, 1'b0);
    chk({tag, "_flags"},  flags,     3'b000);
    chk({tag, "_halted"}, halted,    1'b0);
    chk({tag, "_ready"},  in_ready,  1'b1);
    set_in(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic compare_model(input int cyc);
    chk($sformatf("rnd%0d_ready", cyc),  in_ready,  model_ready());
    chk($sformatf("rnd%0d_valid", cyc),  out_valid, mq.size() > 0);
    chk($sformatf("rnd%0d_flags", cyc),  flags,     mflags);
    chk($sformatf("rnd%0d_halted", cyc), halted,    mhalted);
    if (mq.size() > 0) begin
      chk($sformatf("rnd%0d_result", cyc), out_result, mq[0].result);
      chk($sformatf("rnd%0d_dst", cyc),    out_dst,    mq[0].dst);
      chk($sformatf("rnd%0d_wr_en", cyc),  out_wr_en,  mq[0].wr_en);
      chk($sformatf("rnd%0d_op", cyc),     out_opcode, mq[0].op);
    end
  endtask

  initial begin
    //           v     op     sum       ovfl  dst    flags   valid result     ready
    vecs[0]  = '{1'b1, 4'h0, 16'h0000, 1'b0, 4'h1, 3'b100, 1'b1, 16'h0000, 1'b1};
    vecs[1]  = '{1'b1, 4'h1, 16'h8000, 1'b1, 4'h2, 3'b011, 1'b1, 16'h8000, 1'b1};
    vecs[2]  = '{1'b1, 4'h2, 16'h0000, 1'b0, 4'h3, 3'b111, 1'b1, 16'h0000, 1'b1};
    vecs[3]  = '{1'b1, 4'h8, 16'h0000, 1'b1, 4'h4, 3'b111, 1'b1, 16'h0000, 1'b1};
    vecs[4]  = '{1'b1, 4'h0, 16'h7FFF, 1'b1, 4'h5, 3'b010, 1'b1, 16'h7FFF, 1'b1};
    vecs[5]  = '{1'b1, 4'h4, 16'h1234, 1'b1, 4'h6, 3'b010, 1'b1, 16'h1234, 1'b1};
    vecs[6]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 3'b010, 1'b0, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 4'h0, 16'h8001, 1'b0, 4'h7, 3'b001, 1'b1, 16'h8001, 1'b1};
    vecs[8]  = '{1'b1, 4'h6, 16'h0000, 1'b0, 4'h8, 3'b101, 1'b1, 16'h0000, 1'b1};
    vecs[9]  = '{1'b1, 4'h5, 16'h0005, 1'b0, 4'h9, 3'b001, 1'b1, 16'h0005, 1'b1};
    vecs[10] = '{1'b1, 4'h9, 16'h0000, 1'b1, 4'hA, 3'b001, 1'b1, 16'h0000, 1'b1};
    vecs[11] = '{1'b1, 4'h3, 16'h0000, 1'b0, 4'hB, 3'b001, 1'b1, 16'h0000, 1'b1};

    // Reset values while reset is held
    rst_n = 1'b0;
    set_in(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    model_clear();
    #1;
    chk("rst_ready",  in_ready,  1'b1);
    chk("rst_valid",  out_valid, 1'b0);
    chk("rst_flags",  flags,     3'b000);
    chk("rst_halted", halted,    1'b0);
    chk("rst_wr_en",  out_wr_en, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table, memory stage always ready
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].v, vecs[i].op, vecs[i].sum, vecs[i].ovfl, vecs[i].dst, 1'b1, 1'b1, 1'b0);
      tick();
      chk($sformatf("vec%0d_flags", i), flags,     vecs[i].e_flags);
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_ready", i), in_ready,  vecs[i].e_ready);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_result", i), out_result, vecs[i].e_result);
        chk($sformatf("vec%0d_dst", i),    out_dst,    vecs[i].dst);
        chk($sformatf("vec%0d_op", i),     out_opcode, vecs[i].op);
      end
    end

    // Backpressure: third push refused while full, order preserved on drain
    do_reset();
    set_in(1'b1, 4'h0, 16'h0011, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_ready1", in_ready, 1'b1);
    set_in(1'b1, 4'h0, 16'h0022, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_ready2", in_ready, 1'b0);
    set_in(1'b1, 4'h0, 16'h0033, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_head_hold", out_dst,  4'h1);
    chk("bp_ready3",    in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp_head2",     out_dst,    4'h2);
    chk("bp_head2_res", out_result, 16'h0022);
    chk("bp_ready4",    in_ready,   1'b1);
    tick();
    chk("bp_head3",     out_dst,    4'h3);
    chk("bp_head3_res", out_result, 16'h0033);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // Flush while full with a push offered, then flush while ONE with a push
    do_reset();
    set_in(1'b1, 4'h0, 16'h0000, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 4'h1, 16'h8000, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl_pre_flags", flags, 3'b011);
    set_in(1'b1, 4'h0, 16'h0000, 1'b0, 4'h3, 1'b1, 1'b0, 1'b1);
    tick();
    chk("fl_full_valid", out_valid, 1'b0);
    chk("fl_full_ready", in_ready,  1'b1);
    chk("fl_full_flags", flags,     3'b011);
    set_in(1'b1, 4'h2, 16'h0000, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl_one_flags", flags, 3'b111);
    set_in(1'b1, 4'h0, 16'h0005, 1'b0, 4'h4, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fl_one_valid", out_valid, 1'b0);
    chk("fl_one_flags2", flags,    3'b111);
    set_in(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("fl_push_dropped", out_valid, 1'b0);

    // HLT: blocks pushes once accepted, halted the cycle after it pops
    do_reset();
    set_in(1'b1, 4'h0, 16'h0001, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 4'hF, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("hlt_ready0", in_ready, 1'b0);
    chk("hlt_flags",  flags,    3'b000);
    set_in(1'b1, 4'h0, 16'h0000, 1'b0, 4'h6, 1'b1, 1'b1, 1'b0);
    tick();
    chk("hlt_head_op",  out_opcode, 4'hF);
    chk("hlt_not_yet",  halted,     1'b0);
    chk("hlt_ready1",   in_ready,   1'b0);
    tick();
    chk("hlt_halted",   halted,     1'b1);
    chk("hlt_empty",    out_valid,  1'b0);
    chk("hlt_ready2",   in_ready,   1'b0);
    tick();
    tick();
    chk("hlt_no_push",  out_valid,  1'b0);
    flush = 1'b1;
    tick();
    chk("hlt_flush_keeps", halted, 1'b1);
    async_rst_check("arst_halt");

    // Async reset with a full buffer
    set_in(1'b1, 4'h0, 16'h8000, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("arst_pre_valid", out_valid, 1'b1);
    async_rst_check("arst_full");

    // Randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] s;
      logic [3:0]  op;
      if (c % 250 == 0) do_reset();
      case ($urandom_range(0, 3))
        0:       s = 16'h0000;
        1:       s = 16'h7FFF;
        2:       s = 16'h8000;
        default: s = 16'($urandom);
      endcase
      op = ($urandom_range(0, 47) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      set_in($urandom_range(0, 3) != 0, op, s, 1'($urandom), 4'($urandom),
             1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      tick();
      compare_model(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
